// File: rtl/note_player.sv
// Square-wave note player: latches a pitch index and a duration in ms on start,
// plays the tone, holds a silent gap, then pulses done.
//
// state | meaning
// IDLE  | waiting for start
// PLAY  | tone running for dur_ms milliseconds
// REST  | silent gap of GAP_MS milliseconds (one cycle when GAP_MS is 0)
`timescale 1ns/1ps
module note_player #(
   parameter int CLK_MHZ = 20,
   parameter int NOTES   = 8,
   parameter int CNT_W   = 21,
   parameter int MS_W    = 12,
   parameter int GAP_MS  = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      note_sel,
   input  logic [MS_W-1:0] dur_ms,
   input  logic            mute,
   output logic            busy,
   output logic            done,
   output logic            speaker
);

   typedef enum logic [1:0] {IDLE, PLAY, REST} state_t;

   localparam logic [CNT_W-1:0] MS_LIM = CNT_W'(CLK_MHZ * 1000 - 1);
   localparam logic [MS_W-1:0]  GAP_N  = MS_W'(GAP_MS);

   state_t            state, state_nxt;
   logic [2:0]        note_q;
   logic [MS_W-1:0]   dur_q;
   logic [CNT_W-1:0]  pre_cnt;
   logic [MS_W-1:0]   ms_cnt;
   logic [CNT_W-1:0]  hp_cnt;
   logic              tone;
   logic              ms_tick;
   logic              entry;
   logic              note_ok;

   // Half-period table in us, converted to a terminal count in clock cycles.
   function automatic logic [CNT_W-1:0] hp_lim(input logic [2:0] idx);
      int us;
      us = 0;
      case (idx)
         3'd0: us = 1911;
         3'd1: us = 1703;
         3'd2: us = 1517;
         3'd3: us = 1432;
         3'd4: us = 1276;
         3'd5: us = 1136;
         3'd6: us = 1012;
         3'd7: us = 956;
         default: us = 0;
      endcase
      return CNT_W'(CLK_MHZ * us - 1);
   endfunction

   assign ms_tick = (pre_cnt == MS_LIM);
   assign entry   = (state_nxt != state);
   assign note_ok = (int'(note_q) < NOTES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (dur_ms == '0) ? REST : PLAY;
         PLAY: if (ms_tick && ((ms_cnt + MS_W'(1)) == dur_q)) state_nxt = REST;
         REST: begin
            if (GAP_MS == 0)
               state_nxt = IDLE;
            else if (ms_tick && ((ms_cnt + MS_W'(1)) == GAP_N))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      speaker = tone & (state == PLAY) & ~mute & note_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         note_q <= '0;
         dur_q  <= '0;
      end else if (state == IDLE && start) begin
         note_q <= note_sel;
         dur_q  <= dur_ms;
      end
   end

   // Ms timer restarts on every state change so each phase is measured from its own entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         ms_cnt  <= '0;
      end else if (entry || state == IDLE) begin
         pre_cnt <= '0;
         ms_cnt  <= '0;
      end else if (ms_tick) begin
         pre_cnt <= '0;
         ms_cnt  <= ms_cnt + MS_W'(1);
      end else begin
         pre_cnt <= pre_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hp_cnt <= '0;
         tone   <= 1'b0;
      end else if (state != PLAY) begin
         hp_cnt <= '0;
         tone   <= 1'b0;
      end else if (note_ok) begin
         if (hp_cnt == hp_lim(note_q)) begin
            hp_cnt <= '0;
            tone   <= ~tone;
         end else begin
            hp_cnt <= hp_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) done <= 1'b0;
      else     done <= (state == REST) && (state_nxt == IDLE);
   end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player at CLK_MHZ=1, GAP_MS=2: expected done cycles go through a
// scoreboard queue; speaker/busy are compared against a cycle model per note.
`timescale 1ns/1ps
module tb_note_player;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  note_sel;
   logic [11:0] dur_ms;
   logic        mute;
   logic        busy;
   logic        done;
   logic        speaker;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int exp_q[$];
   int hp_tab[8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

   note_player #(.CLK_MHZ(1), .NOTES(8), .CNT_W(21), .MS_W(12), .GAP_MS(GAP)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .note_sel (note_sel),
      .dur_ms   (dur_ms),
      .mute     (mute),
      .busy     (busy),
      .done     (done),
      .speaker  (speaker)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One note: start, then a cycle-by-cycle model of busy and speaker until the gap ends.
   task automatic play_note(input int n, input int dur, input int ign_at,
                            input int mute_from, input int mute_to, input string tag);
      int t, hp, play_len, total, err_spk, err_busy;
      logic exp_spk;
      @(negedge clk);
      note_sel = 3'(n);
      dur_ms   = 12'(dur);
      start    = 1'b1;
      t        = cyc + 1;
      hp       = hp_tab[n];
      play_len = dur * 1000;
      total    = play_len + GAP * 1000;
      exp_q.push_back(t + total);
      err_spk  = 0;
      err_busy = 0;
      for (int i = 0; i < total; i++) begin
         @(negedge clk);
         start = (i == ign_at);
         if (i == ign_at) begin
            note_sel = 3'(n + 1);
            dur_ms   = 12'd0;
         end
         mute = (i >= mute_from) && (i < mute_to);
         #1;
         exp_spk = (i < play_len) && (((i / hp) % 2) == 1) && !mute;
         if (speaker !== exp_spk) err_spk++;
         if (busy !== 1'b1) err_busy++;
      end
      start = 1'b0;
      mute  = 1'b0;
      chk({tag, "_speaker_errs"}, err_spk, 0);
      chk({tag, "_busy_errs"}, err_busy, 0);
   endtask

   task automatic idle(input int n, input string tag);
      int err;
      err = 0;
      repeat (n) begin
         @(negedge clk);
         #1;
         if (busy !== 1'b0 || speaker !== 1'b0) err++;
      end
      chk({tag, "_idle_errs"}, err, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      note_sel = 3'd0;
      dur_ms   = 12'd0;
      mute     = 1'b0;

      fork
         forever begin
            int e;
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("done_unexpected", cyc, -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_cycle", cyc, e);
                  chk("done_busy", int'(busy), 0);
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_speaker", int'(speaker), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(5, "post_reset");

      // Async reset in the middle of a high speaker half-period.
      @(negedge clk);
      note_sel = 3'd6;
      dur_ms   = 12'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (1100) @(negedge clk);
      #1;
      chk("pre_rst_speaker", int'(speaker), 1);
      rst = 1'b1;
      #1;
      chk("rst_speaker", int'(speaker), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(20, "after_rst");

      play_note(6, 3, -1, -1, -1, "n6_d3");
      idle(3, "gap1");
      play_note(0, 1, -1, -1, -1, "n0_d1");
      idle(3, "gap2");
      play_note(3, 0, -1, -1, -1, "dur0");
      idle(3, "gap3");
      // Ignored start while busy, then a start in the done cycle.
      play_note(2, 1, 300, -1, -1, "busy_start");
      play_note(4, 1, -1, -1, -1, "back2back");
      idle(3, "gap4");
      play_note(7, 2, 500, 500, 1500, "mute_n7");
      idle(5, "final");

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
